dht11_uart_reporter: RTL and testbench
======================================

DHT11_UART_REPORTER -- requirements
Module: dht11_uart_reporter

Interface
REQ-001 SHALL have parameter PERIOD_CYCLES, default 1000000, meaning the auto-report interval in clk cycles (1 s at 1 MHz).
REQ-002 SHALL have parameter AUTO_EN, default 1, meaning 1 enables the periodic trigger and 0 leaves report_req as the only trigger.
REQ-003 SHALL have port clk, input, 1, the single system clock.
REQ-004 SHALL have port rst, input, 1, reset that is asynchronous and active-high.
REQ-005 SHALL have port report_req, input, 1, a one-cycle pulse requesting a report frame.
REQ-006 SHALL have port hum_int, input, 8, humidity integer part (binary, 0-255).
REQ-007 SHALL have port temp_int, input, 8, temperature integer part (binary, 0-255).
REQ-008 SHALL have port data_valid, input, 1, meaning the last sensor read passed checksum.
REQ-009 SHALL have port tx_start, output, 1, a one-cycle start pulse to the UART transmitter.
REQ-010 SHALL have port tx_data, output, 8, the byte to transmit, stable from tx_start until tx_done.
REQ-011 SHALL have ports tx_done (input, 1, transmitter byte-complete pulse) and tx_busy (input, 1, transmitter busy level).
REQ-012 SHALL have ports busy (output, 1, frame in progress) and frame_done (output, 1, one-cycle pulse after the last byte).

Function
REQ-013 Frame SHALL be the 13 ASCII bytes "H=hhh T=ttt" CR LF, where hhh/ttt are 3-digit zero-padded decimal values (e.g. 7 -> "007").
REQ-014 If data_valid=0 at frame start, each digit SHALL be replaced by '-' (0x2D); the byte count stays 13.
REQ-015 hum_int, temp_int and data_valid SHALL be captured on the trigger-accepting edge; later input changes SHALL NOT affect the frame in flight.
REQ-016 FSM states SHALL be IDLE, CONVERT (8 cycles), LOAD, START, WAIT_DONE, NEXT.
- IDLE -> CONVERT on trigger.
- CONVERT -> LOAD after 8 cycles.
- LOAD -> START.
- START -> WAIT_DONE.
- WAIT_DONE -> NEXT on tx_done.
- NEXT -> START if bytes remain, else IDLE with frame_done.
REQ-017 The first tx_start SHALL be asserted exactly 10 cycles after the edge that accepts the trigger.
REQ-018 START SHALL assert tx_start for exactly one cycle, and only when tx_busy=0; if tx_busy=1, START holds with tx_start low.
REQ-019 After tx_done is sampled high at edge M, the next tx_start SHALL occur at edge M+2 at the earliest (the NEXT state adds one cycle).
REQ-020 A tx_done seen outside WAIT_DONE SHALL be ignored.
REQ-021 The byte index SHALL run 0..12; frame_done SHALL pulse for 1 cycle at the NEXT->IDLE transition; busy=1 in every state except IDLE.
REQ-022 The trigger SHALL be report_req OR (AUTO_EN and period timer expiry).
- The timer is free-running 0..PERIOD_CYCLES-1 and expires on the wrap.
REQ-023 A trigger arriving while busy=1 SHALL set a single pending flag (extra triggers coalesce).
- The pending frame starts from IDLE on the cycle after frame_done.
- Its data is captured at that start.
REQ-024 A trigger coinciding with frame_done SHALL become pending and not be lost.

Reset
REQ-025 While rst=1, outputs SHALL be: tx_start=0, tx_data=0x00, busy=0, frame_done=0; state=IDLE, pending=0, timer=0, byte index=0.
REQ-026 rst asserted mid-frame SHALL abort the frame immediately with no further tx_start; after release, the block waits for a new trigger.

Structure
REQ-027 Frame template bytes ('H','=',' ','T',CR,LF,'-'), the state encoding and the frame length 13 SHALL live in a shared package.
REQ-028 Binary-to-BCD conversion SHALL be a sub-module bin2bcd8: sequential shift-add-3, 8 cycles, start/done handshake, outputs 3 BCD digits.

Verification
REQ-029 Verify: hum=45, temp=23, valid=1, report_req pulse -> tx_data sequence 48 3D 30 34 35 20 54 3D 30 32 33 0D 0A, one tx_start per byte, then frame_done once.
REQ-030 Verify: hum=255, temp=0, valid=0 -> "H=--- T=---" CR LF.
REQ-031 Verify: report_req at edge N -> first tx_start at edge N+10; with a tx_done model 1 cycle after each tx_start, the next tx_start comes 2 cycles after tx_done.
REQ-032 Verify: three report_req pulses during a frame -> exactly one additional frame, starting the cycle after frame_done.
REQ-033 Verify: rst pulse during byte 5 -> tx_start stays 0 thereafter, busy=0, and no frame_done.
REQ-034 Verify: AUTO_EN=1, PERIOD_CYCLES=200, no report_req -> a frame starts every 200 cycles; tx_busy held high for 50 cycles delays tx_start with no byte lost.

Source files
------------

// File: rtl/dht11_uart_reporter_pkg.sv
// Shared constants for the DHT11 UART reporter: frame template
// characters, frame length, FSM state encoding and byte lookup.
package dht11_uart_reporter_pkg;

  localparam int unsigned FRAME_LEN = 13;
  localparam logic [3:0]  LAST_IDX  = 4'(FRAME_LEN - 1);

  localparam logic [7:0] CH_H    = 8'h48;
  localparam logic [7:0] CH_EQ   = 8'h3D;
  localparam logic [7:0] CH_SP   = 8'h20;
  localparam logic [7:0] CH_T    = 8'h54;
  localparam logic [7:0] CH_CR   = 8'h0D;
  localparam logic [7:0] CH_LF   = 8'h0A;
  localparam logic [7:0] CH_DASH = 8'h2D;
  localparam logic [7:0] CH_ZERO = 8'h30;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONVERT,
    S_LOAD,
    S_START,
    S_WAIT_DONE,
    S_NEXT
  } state_e;

  function automatic logic [7:0] digit_char(
    input logic [3:0] d,
    input logic       valid
  );
    return valid ? (CH_ZERO | {4'h0, d}) : CH_DASH;
  endfunction

  // Byte idx of "H=hhh T=ttt\r\n"; hum/temp are 3 BCD digits.
  function automatic logic [7:0] frame_byte(
    input logic [3:0]  idx,
    input logic [11:0] hum,
    input logic [11:0] temp,
    input logic        valid
  );
    logic [7:0] b;
    case (idx)
      4'd0:    b = CH_H;
      4'd1:    b = CH_EQ;
      4'd2:    b = digit_char(hum[11:8], valid);
      4'd3:    b = digit_char(hum[7:4], valid);
      4'd4:    b = digit_char(hum[3:0], valid);
      4'd5:    b = CH_SP;
      4'd6:    b = CH_T;
      4'd7:    b = CH_EQ;
      4'd8:    b = digit_char(temp[11:8], valid);
      4'd9:    b = digit_char(temp[7:4], valid);
      4'd10:   b = digit_char(temp[3:0], valid);
      4'd11:   b = CH_CR;
      4'd12:   b = CH_LF;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/dht11_uart_reporter_bin2bcd8.sv
// 8-bit binary to 3-digit BCD, sequential shift-add-3 over 8 cycles.
// Ports: clk_i, rst_i, start_i (loads bin_i), done_o, bcd_o.
module bin2bcd8 (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [7:0]  bin_i,
  output logic        done_o,
  output logic [11:0] bcd_o
);

  logic [19:0] sr_q, sr_d;
  logic [19:0] adj;
  logic [3:0]  cnt_q, cnt_d;

  always_comb begin
    adj = sr_q;
    for (int n = 0; n < 3; n++) begin
      if (adj[8+4*n +: 4] > 4'd4)
        adj[8+4*n +: 4] = adj[8+4*n +: 4] + 4'd3;
    end
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (start_i) begin
      sr_d  = {12'd0, bin_i};
      cnt_d = 4'd8;
    end else if (cnt_q != 4'd0) begin
      sr_d  = {adj[18:0], 1'b0};
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  // High in the cycle whose closing edge performs the final step.
  assign done_o = (cnt_q == 4'd1);
  assign bcd_o  = sr_q[19:8];

endmodule

// File: rtl/dht11_uart_reporter.sv
// Formats humidity/temperature as "H=hhh T=ttt\r\n" and streams it
// byte by byte to a UART (tx_start/tx_data/tx_done/tx_busy).
module dht11_uart_reporter
  import dht11_uart_reporter_pkg::*;
#(
  parameter int unsigned PERIOD_CYCLES = 1000000,
  parameter bit          AUTO_EN       = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       report_req,
  input  logic [7:0] hum_int,
  input  logic [7:0] temp_int,
  input  logic       data_valid,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_done,
  input  logic       tx_busy,
  output logic       busy,
  output logic       frame_done
);

  localparam int unsigned TW =
    (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(PERIOD_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic        pend_q, pend_d;
  logic        valid_q, valid_d;
  logic [7:0]  data_q, data_d;
  logic [TW-1:0] tmr_q, tmr_d;

  logic        expire, trig;
  logic        conv_start, hum_done, temp_done;
  logic [11:0] hum_bcd, temp_bcd;

  assign expire = (tmr_q == T_LAST);
  assign tmr_d  = expire ? '0 : tmr_q + TW'(1);
  assign trig   = report_req | (AUTO_EN & expire);

  bin2bcd8 u_hum (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (conv_start),
    .bin_i   (hum_int),
    .done_o  (hum_done),
    .bcd_o   (hum_bcd)
  );

  bin2bcd8 u_temp (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (conv_start),
    .bin_i   (temp_int),
    .done_o  (temp_done),
    .bcd_o   (temp_bcd)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    pend_d     = pend_q;
    valid_d    = valid_q;
    data_d     = data_q;
    conv_start = 1'b0;
    tx_start   = 1'b0;
    frame_done = 1'b0;
    busy       = (state_q != S_IDLE);
    unique case (state_q)
      S_IDLE: begin
        if (trig || pend_q) begin
          state_d    = S_CONVERT;
          conv_start = 1'b1;
          valid_d    = data_valid;
          pend_d     = 1'b0;
          idx_d      = 4'd0;
        end
      end
      S_CONVERT: begin
        if (hum_done && temp_done)
          state_d = S_LOAD;
      end
      S_LOAD: begin
        data_d  = frame_byte(idx_q, hum_bcd, temp_bcd, valid_q);
        state_d = S_START;
      end
      S_START: begin
        if (!tx_busy) begin
          tx_start = 1'b1;
          state_d  = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (tx_done)
          state_d = S_NEXT;
      end
      S_NEXT: begin
        if (idx_q == LAST_IDX) begin
          frame_done = 1'b1;
          state_d    = S_IDLE;
        end else begin
          idx_d   = idx_q + 4'd1;
          data_d  = frame_byte(idx_q + 4'd1, hum_bcd,
                               temp_bcd, valid_q);
          state_d = S_START;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Includes the frame_done cycle, so that trigger is not lost.
    if (busy && trig)
      pend_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      pend_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      tmr_q   <= tmr_d;
    end
  end

  assign tx_data = data_q;

endmodule

// File: tb/tb_dht11_uart_reporter.sv
// Self-checking bench for dht11_uart_reporter: frame-level reference
// model, per-cycle compare, directed literals and random stimulus.
module tb_dht11_uart_reporter;

  localparam int P = 200;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       report_req = 1'b0;
  logic [7:0] hum_int = '0;
  logic [7:0] temp_int = '0;
  logic       data_valid = 1'b0;
  logic       tx_done = 1'b0;
  logic       tx_busy = 1'b0;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       busy;
  logic       frame_done;

  dht11_uart_reporter #(
    .PERIOD_CYCLES (P),
    .AUTO_EN       (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .report_req (report_req),
    .hum_int    (hum_int),
    .temp_int   (temp_int),
    .data_valid (data_valid),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_done    (tx_done),
    .tx_busy    (tx_busy),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: frame as a byte array plus timing rules.
  int         edge_no = 0;
  int         kk = 0;
  bit         m_act = 0, m_pend = 0, m_await = 0;
  int         m_idx = 0, m_earliest = 0, m_fin = -1;
  logic [7:0] m_bytes [13];

  // Transmitter / stimulus controls.
  int  done_at = -1;
  bit  rand_delay = 0, spur_en = 0, busy_rand = 0;
  int  hold_cnt = 0;
  bit  use_fix = 0;
  int  fix_h, fix_t;
  bit  fix_v;

  logic [7:0] obs_q [$];
  int start_edges [$];
  int fd_edges [$];
  int accept_edges [$];

  logic [7:0] lit_a [13] = '{8'h48, 8'h3D, 8'h30, 8'h34, 8'h35,
    8'h20, 8'h54, 8'h3D, 8'h30, 8'h32, 8'h33, 8'h0D, 8'h0A};
  logic [7:0] lit_b [13] = '{8'h48, 8'h3D, 8'h2D, 8'h2D, 8'h2D,
    8'h20, 8'h54, 8'h3D, 8'h2D, 8'h2D, 8'h2D, 8'h0D, 8'h0A};

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)",
               nm, act, exp, edge_no);
    end
  endfunction

  function automatic void build(int h, int t, bit v);
    string s;
    if (v) s = $sformatf("H=%03d T=%03d", h, t);
    else   s = "H=--- T=---";
    for (int i = 0; i < 11; i++) m_bytes[i] = s[i];
    m_bytes[11] = 8'h0D;
    m_bytes[12] = 8'h0A;
  endfunction

  function automatic void clear_obs();
    obs_q.delete();
    start_edges.delete();
    fd_edges.delete();
    accept_edges.delete();
  endfunction

  // One clock: drive inputs, compare, advance the model past the edge.
  task automatic step(input bit req, input bit rst_v);
    bit e_start, e_fd, e_busy, tick, trig;
    @(negedge clk);
    rst        = rst_v;
    report_req = req;
    if (use_fix) begin
      hum_int    = 8'(fix_h);
      temp_int   = 8'(fix_t);
      data_valid = fix_v;
    end else begin
      hum_int    = 8'($urandom);
      temp_int   = 8'($urandom);
      data_valid = 1'($urandom);
    end
    if (rst_v) begin
      m_act = 0; m_pend = 0; m_await = 0;
      kk = 0; done_at = -1;
    end
    tx_busy = (hold_cnt > 0) ||
              (busy_rand && $urandom_range(3) == 0);
    if (hold_cnt > 0) hold_cnt--;
    e_busy  = m_act;
    e_start = m_act && !m_await && m_idx < 13 &&
              edge_no >= m_earliest && !tx_busy;
    e_fd    = m_act && edge_no == m_fin;
    tx_done = (edge_no == done_at);
    if (!tx_done && spur_en && !m_await && !e_start &&
        $urandom_range(7) == 0)
      tx_done = 1'b1;
    #1;
    chk("busy", 32'(busy), 32'(e_busy));
    chk("tx_start", 32'(tx_start), 32'(e_start));
    chk("frame_done", 32'(frame_done), 32'(e_fd));
    if (rst_v)
      chk("tx_data_rst", 32'(tx_data), 32'h0);
    else if (m_act && m_idx < 13 && (e_start || m_await))
      chk("tx_data", 32'(tx_data), 32'(m_bytes[m_idx]));
    if (tx_start && !rst_v) begin
      obs_q.push_back(tx_data);
      start_edges.push_back(edge_no);
      done_at = edge_no + (rand_delay ? $urandom_range(1, 4) : 1);
    end
    if (frame_done) fd_edges.push_back(edge_no);
    if (!rst_v) begin
      tick = (kk % P) == P - 1;
      kk++;
      trig = req || tick;
      if (m_act) begin
        if (e_start) m_await = 1;
        else if (m_await && tx_done) begin
          m_await = 0;
          m_idx++;
          if (m_idx == 13) m_fin = edge_no + 1;
          else m_earliest = edge_no + 2;
        end
        if (e_fd) m_act = 0;
        if (trig) m_pend = 1;
      end else if (trig || m_pend) begin
        m_act = 1; m_pend = 0; m_await = 0;
        m_idx = 0; m_fin = -1;
        m_earliest = edge_no + 10;
        build(int'(hum_int), int'(temp_int), data_valid);
        accept_edges.push_back(edge_no);
      end
    end
    edge_no++;
  endtask

  task automatic check_frame(string nm, logic [7:0] lit [13]);
    chk({nm, "_len"}, 32'(obs_q.size()), 32'd13);
    for (int i = 0; i < 13; i++) begin
      if (i < obs_q.size())
        chk({nm, "_byte"}, 32'(obs_q[i]), 32'(lit[i]));
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) step(0, 1);
    for (int i = 0; i < 3; i++) step(0, 0);

    // Frame A: 45 / 23 / valid, exact timing.
    clear_obs();
    use_fix = 1; fix_h = 45; fix_t = 23; fix_v = 1;
    step(1, 0);
    use_fix = 0;
    for (int i = 0; i < 60; i++) step(0, 0);
    check_frame("frameA", lit_a);
    chk("frameA_fd_count", 32'(fd_edges.size()), 32'd1);
    if (accept_edges.size() > 0 && start_edges.size() > 1) begin
      chk("first_start_lat", 32'(start_edges[0] - accept_edges[0]),
          32'd10);
      chk("done_to_start", 32'(start_edges[1] - start_edges[0]),
          32'd3);
    end else chk("frameA_started", 32'd0, 32'd1);
    if (fd_edges.size() > 0 && start_edges.size() == 13)
      chk("fd_edge", 32'(fd_edges[0] - start_edges[12]), 32'd2);

    // Frame B: invalid data gives dashes.
    clear_obs();
    use_fix = 1; fix_h = 255; fix_t = 0; fix_v = 0;
    step(1, 0);
    use_fix = 0;
    for (int i = 0; i < 55; i++) step(0, 0);
    check_frame("frameB", lit_b);

    // Coalescing: three requests during a frame -> one extra frame.
    for (int i = 0; i < 3; i++) step(0, 1);
    clear_obs();
    step(1, 0);
    for (int i = 1; i < 120; i++)
      step(i == 10 || i == 20 || i == 30, 0);
    chk("coalesce_frames", 32'(accept_edges.size()), 32'd2);
    chk("coalesce_fd", 32'(fd_edges.size()), 32'd2);
    if (accept_edges.size() > 1 && fd_edges.size() > 0)
      chk("pending_start", 32'(accept_edges[1] - fd_edges[0]),
          32'd1);

    // Reset during byte 5 aborts the frame.
    clear_obs();
    step(1, 0);
    for (int i = 0; i < 60 && !(m_act && m_idx == 5); i++)
      step(0, 0);
    chk("reach_byte5", 32'(m_idx), 32'd5);
    for (int i = 0; i < 3; i++) step(0, 1);
    clear_obs();
    for (int i = 0; i < 100; i++) step(0, 0);
    chk("rst_no_start", 32'(start_edges.size()), 32'd0);
    chk("rst_no_fd", 32'(fd_edges.size()), 32'd0);

    // Auto trigger every P cycles; tx_busy stall in first frame.
    clear_obs();
    for (int i = 0; i < 650; i++) begin
      if (accept_edges.size() == 1 &&
          edge_no == accept_edges[0] + 12)
        hold_cnt = 50;
      step(0, 0);
    end
    chk("auto_frames", 32'(accept_edges.size()), 32'd3);
    chk("auto_fd", 32'(fd_edges.size()), 32'd3);
    chk("auto_bytes", 32'(start_edges.size()), 32'd39);
    for (int i = 1; i < accept_edges.size(); i++)
      chk("auto_period", 32'(accept_edges[i] - accept_edges[i-1]),
          32'd200);

    // Random traffic with stalls, slow tx and stray tx_done.
    rand_delay = 1; spur_en = 1; busy_rand = 1;
    for (int i = 0; i < 3000; i++)
      step($urandom_range(39) == 0, 0);
    if ($urandom_range(1) == 0) begin
      for (int i = 0; i < 2; i++) step(0, 1);
      for (int i = 0; i < 200; i++)
        step($urandom_range(29) == 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
